dma_controller: RTL and testbench

//  Bus-master DMA engine that moves device data into data memory for the pipelined CPU.
//  On a CPU command (cmd) it requests the D-memory bus (BR), waits for grant (BG), then writes

---
 rtl/dma_pkg.sv | 19 +
 rtl/dma_lat_timer.sv | 32 +++
 rtl/dma_controller.sv | 182 ++++++++++++++++++
 tb/tb_dma_controller.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA engine: state encoding, burst geometry
// and the default bus widths used by the controller.
package dma_pkg;

    localparam int DMA_WORD_SIZE   = 16;
    localparam int DMA_FETCH_SIZE  = 64;
    localparam int DMA_BURST_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        LOAD    = 3'd2,
        WRITE   = 3'd3,
        NEXT    = 3'd4,
        RELEASE = 3'd5,
        DONE    = 3'd6
    } dma_state_e;

endpackage

// File: rtl/dma_lat_timer.sv
// Loadable down-counter that times the memory write window; it freezes while
// hold is high and flags expire on the last counted cycle.
module dma_lat_timer #(
    parameter int MEM_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic hold,
    output logic expire
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= LOAD_VAL;
        end else if (!hold && count != '0) begin
            count <= count - ONE;
        end
    end

    // Terminal count: this cycle is the last one of the window.
    assign expire = (count == ONE) && !hold;

endmodule

// File: rtl/dma_controller.sv
// Bus-master DMA engine: takes a CPU command, acquires the D-memory bus and
// writes device bursts to consecutive aligned addresses, then signals completion.
//
//  state   | meaning
//  IDLE    | waiting for cmd
//  REQ     | BR raised, waiting for BG
//  LOAD    | dev_ready high, waiting for a device burst
//  WRITE   | d_writeM held for MEM_LAT granted cycles
//  NEXT    | advance address, count the burst off
//  RELEASE | BR dropped, waiting for BG to fall (plus a one-cycle gap if more work)
//  DONE    | emit dma_end on the following cycle
module dma_controller
    import dma_pkg::*;
#(
    parameter int WORD_SIZE   = DMA_WORD_SIZE,
    parameter int FETCH_SIZE  = DMA_FETCH_SIZE,
    parameter int MEM_LAT     = 4,
    parameter bit CYCLE_STEAL = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd,
    input  logic [WORD_SIZE-1:0]  dst_addr,
    input  logic [WORD_SIZE-1:0]  length,
    output logic                  BR,
    input  logic                  BG,
    output logic                  d_writeM,
    output logic [WORD_SIZE-1:0]  d_address,
    output logic [FETCH_SIZE-1:0] d_data,
    input  logic                  dev_valid,
    input  logic [FETCH_SIZE-1:0] dev_data,
    output logic                  dev_ready,
    output logic                  dma_end,
    output logic                  busy
);

    localparam int BW_SHIFT = $clog2(DMA_BURST_WORDS);
    localparam logic [WORD_SIZE-1:0] ADDR_STEP  = WORD_SIZE'(DMA_BURST_WORDS);
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(DMA_BURST_WORDS - 1);
    localparam logic [WORD_SIZE-1:0] ONE        = WORD_SIZE'(1);

    dma_state_e state, next_state;

    logic [WORD_SIZE-1:0]  addr_q;
    logic [WORD_SIZE-1:0]  bursts_q;
    logic [FETCH_SIZE-1:0] data_q;
    logic                  br_q;
    logic                  ready_q;
    logic                  write_q;
    logic                  end_q;
    logic                  busy_q;
    logic                  gap_q, gap_next;

    logic                  accept;
    logic                  capture;
    logic                  timer_start;
    logic                  timer_hold;
    logic                  timer_expire;
    logic                  own;
    logic [WORD_SIZE-1:0]  len_bursts;

    assign accept     = (state == IDLE) && cmd;
    assign len_bursts = length >> BW_SHIFT;
    assign timer_hold = !BG;

    dma_lat_timer #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (timer_start),
        .hold   (timer_hold),
        .expire (timer_expire)
    );

    always_comb begin
        next_state  = state;
        gap_next    = gap_q;
        capture     = 1'b0;
        timer_start = 1'b0;
        case (state)
            IDLE: begin
                if (cmd) begin
                    next_state = (len_bursts == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (BG) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                // Without grant the handshake is frozen; nothing is consumed.
                if (BG && dev_valid) begin
                    capture     = 1'b1;
                    timer_start = 1'b1;
                    next_state  = WRITE;
                end
            end
            WRITE: begin
                if (timer_expire) begin
                    next_state = NEXT;
                end
            end
            NEXT: begin
                if (bursts_q == ONE || CYCLE_STEAL) begin
                    next_state = RELEASE;
                end else begin
                    next_state = LOAD;
                end
            end
            RELEASE: begin
                if (!BG) begin
                    if (bursts_q == '0) begin
                        next_state = DONE;
                    end else if (gap_q) begin
                        gap_next   = 1'b0;
                        next_state = REQ;
                    end else begin
                        gap_next = 1'b1;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            bursts_q <= '0;
            data_q   <= '0;
            br_q     <= 1'b0;
            ready_q  <= 1'b0;
            write_q  <= 1'b0;
            end_q    <= 1'b0;
            busy_q   <= 1'b0;
            gap_q    <= 1'b0;
        end else begin
            state   <= next_state;
            gap_q   <= gap_next;
            br_q    <= (next_state == REQ) || (next_state == LOAD) ||
                       (next_state == WRITE) || (next_state == NEXT);
            ready_q <= (next_state == LOAD);
            write_q <= (next_state == WRITE);
            end_q   <= (state == DONE);
            if (accept) begin
                addr_q   <= dst_addr & ALIGN_MASK;
                bursts_q <= len_bursts;
            end else if (state == NEXT) begin
                addr_q   <= addr_q + ADDR_STEP;
                bursts_q <= bursts_q - ONE;
            end
            if (capture) begin
                data_q <= dev_data;
            end
            // busy covers the dma_end cycle, so it clears one cycle after it.
            if (accept) begin
                busy_q <= 1'b1;
            end else if (end_q) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign own = BG && ((state == LOAD) || (state == WRITE) || (state == NEXT));

    assign BR        = br_q;
    assign dev_ready = ready_q && BG;
    assign dma_end   = end_q;
    assign busy      = busy_q;
    assign d_writeM  = own ? write_q : 1'bz;
    assign d_address = own ? addr_q  : {WORD_SIZE{1'bz}};
    assign d_data    = own ? data_q  : {FETCH_SIZE{1'bz}};

endmodule

// File: tb/tb_dma_controller.sv
// Self-checking bench for dma_controller: a table of transfers checked through a
// write scoreboard, plus hand-written sequences for grant loss, stalls and reset.
module tb_dma_controller;

    localparam int WS  = 16;
    localparam int FS  = 64;
    localparam int LAT = 4;

    typedef struct packed {
        logic [WS-1:0] addr;
        logic [FS-1:0] data;
    } wr_t;

    typedef struct {
        int            sel;
        logic [WS-1:0] addr;
        logic [WS-1:0] len;
        logic [WS-1:0] first;
        int            bursts;
        int            end_lat;
        int            rises;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset, cmd0, cmd1, dev_valid, bg_block, sel;
    logic [WS-1:0] dst_addr, length;
    logic [FS-1:0] dev_data;

    wire           br0, br1, w0, w1, rdy0, rdy1, end0, end1, busy0, busy1;
    wire [WS-1:0]  a0, a1;
    wire [FS-1:0]  dd0, dd1;
    wire           bg0 = br0 & ~bg_block;
    wire           bg1 = br1;

    wire           m_w    = sel ? w1 : w0;
    wire [WS-1:0]  m_a    = sel ? a1 : a0;
    wire [FS-1:0]  m_d    = sel ? dd1 : dd0;
    wire           m_br   = sel ? br1 : br0;
    wire           m_bg   = sel ? bg1 : bg0;
    wire           m_rdy  = sel ? rdy1 : rdy0;
    wire           m_end  = sel ? end1 : end0;
    wire           m_busy = sel ? busy1 : busy0;

    dma_controller #(.MEM_LAT(LAT), .CYCLE_STEAL(1'b0)) u_dut (
        .clk(clk), .reset(reset), .cmd(cmd0), .dst_addr(dst_addr), .length(length),
        .BR(br0), .BG(bg0), .d_writeM(w0), .d_address(a0), .d_data(dd0),
        .dev_valid(dev_valid), .dev_data(dev_data), .dev_ready(rdy0),
        .dma_end(end0), .busy(busy0)
    );

    dma_controller #(.MEM_LAT(LAT), .CYCLE_STEAL(1'b1)) u_dut_steal (
        .clk(clk), .reset(reset), .cmd(cmd1), .dst_addr(dst_addr), .length(length),
        .BR(br1), .BG(bg1), .d_writeM(w1), .d_address(a1), .d_data(dd1),
        .dev_valid(dev_valid), .dev_data(dev_data), .dev_ready(rdy1),
        .dma_end(end1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int        errors, checks, cyc, burst_no;
    int        wcount, windows, w_hi, end_cnt, br_rises, first_w_cyc;
    bit        br_prev, dev_en;
    wr_t       cur;
    wr_t       exp_q[$];
    logic [FS-1:0] dev_q[$];
    vec_t      vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic bus_off();
        return (m_w === 1'bz || m_w === 1'b0) &&
               (m_a === {WS{1'bz}} || m_a === {WS{1'b0}}) &&
               (m_d === {FS{1'bz}} || m_d === {FS{1'b0}});
    endfunction

    function automatic logic [FS-1:0] pat(input int n);
        return 64'h1111_1111_1111_1111 * 64'((n % 15) + 1);
    endfunction

    task automatic refresh_dev();
        dev_valid = dev_en && (dev_q.size() > 0);
        dev_data  = (dev_q.size() > 0) ? dev_q[0] : '0;
    endtask

    task automatic clear_mon();
        wcount = 0; windows = 0; w_hi = 0; end_cnt = 0; br_rises = 0; first_w_cyc = -1;
    endtask

    task automatic monitor();
        if (m_w === 1'b1) begin
            if (wcount == 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%0h with no burst outstanding", m_a);
                end else begin
                    cur = exp_q.pop_front();
                    if (first_w_cyc < 0) first_w_cyc = cyc;
                end
            end
            chk("write_addr", 64'(m_a), 64'(cur.addr));
            chk("write_data", m_d, cur.data);
            wcount++;
            w_hi++;
            if (wcount == LAT) begin
                wcount = 0;
                windows++;
            end
        end else if (wcount != 0 && m_bg === 1'b1) begin
            chk("window_length", 64'(wcount), 64'(LAT));
            wcount = 0;
        end
        if (m_bg !== 1'b1) chk("bus_released", 64'(bus_off()), 64'd1);
        if (m_end === 1'b1) end_cnt++;
        if (m_br === 1'b1 && !br_prev) br_rises++;
        br_prev = (m_br === 1'b1);
    endtask

    task automatic step();
        bit hs;
        @(posedge clk);
        hs = (dev_valid === 1'b1) && (m_rdy === 1'b1);
        @(negedge clk);
        cyc++;
        if (hs && dev_q.size() > 0) void'(dev_q.pop_front());
        refresh_dev();
        monitor();
    endtask

    task automatic queue_bursts(input logic [WS-1:0] first, input int n);
        logic [FS-1:0] d;
        for (int k = 0; k < n; k++) begin
            d = pat(burst_no);
            burst_no++;
            exp_q.push_back('{addr: WS'(first + WS'(4 * k)), data: d});
            dev_q.push_back(d);
        end
        refresh_dev();
    endtask

    task automatic issue_cmd(input int s, input logic [WS-1:0] a, input logic [WS-1:0] l);
        dst_addr = a;
        length   = l;
        if (s != 0) cmd1 = 1'b1; else cmd0 = 1'b1;
        step();
        cmd0 = 1'b0;
        cmd1 = 1'b0;
    endtask

    task automatic wait_end(input int limit, output int t);
        t = 1;
        while (end_cnt == 0 && t < limit) begin
            step();
            t++;
        end
    endtask

    initial begin
        int t, c0;
        errors = 0; checks = 0; cyc = 0; burst_no = 0;
        sel = 1'b0; reset = 1'b1; cmd0 = 1'b0; cmd1 = 1'b0; bg_block = 1'b0;
        dst_addr = '0; length = '0; dev_en = 1'b1; br_prev = 1'b0;
        refresh_dev();
        clear_mon();
        step();
        step();
        reset = 1'b0;
        step();
        chk("reset_br", 64'(m_br), 64'd0);
        chk("reset_ready", 64'(m_rdy), 64'd0);
        chk("reset_end", 64'(m_end), 64'd0);
        chk("reset_busy", 64'(m_busy), 64'd0);
        chk("reset_bus_off", 64'(bus_off()), 64'd1);

        // sel, dst_addr, length, first aligned addr, bursts, dma_end cycle, BR rises
        vecs[0] = '{0, 16'h00C8, 16'd8,  16'h00C8, 2, 16, 1};
        vecs[1] = '{0, 16'h0000, 16'd0,  16'h0000, 0, 2,  0};
        vecs[2] = '{0, 16'h0040, 16'd3,  16'h0040, 0, 2,  0};
        vecs[3] = '{0, 16'hFFFD, 16'd8,  16'hFFFC, 2, 16, 1};
        vecs[4] = '{0, 16'h1236, 16'd5,  16'h1234, 1, 10, 1};
        vecs[5] = '{0, 16'h0010, 16'd16, 16'h0010, 4, 28, 1};
        vecs[6] = '{1, 16'h0100, 16'd12, 16'h0100, 3, 28, 3};

        for (int i = 0; i < 7; i++) begin
            sel = (vecs[i].sel != 0);
            step();
            clear_mon();
            queue_bursts(vecs[i].first, vecs[i].bursts);
            c0 = cyc;
            issue_cmd(vecs[i].sel, vecs[i].addr, vecs[i].len);
            chk($sformatf("v%0d_br_cycle1", i), 64'(m_br), 64'(vecs[i].bursts > 0));
            chk($sformatf("v%0d_busy_cycle1", i), 64'(m_busy), 64'd1);
            wait_end(400, t);
            chk($sformatf("v%0d_end_cycle", i), 64'(t), 64'(vecs[i].end_lat));
            chk($sformatf("v%0d_busy_at_end", i), 64'(m_busy), 64'd1);
            if (vecs[i].bursts > 0)
                chk($sformatf("v%0d_first_write_cycle", i), 64'(first_w_cyc - c0), 64'd3);
            step();
            step();
            chk($sformatf("v%0d_busy_after", i), 64'(m_busy), 64'd0);
            chk($sformatf("v%0d_end_pulses", i), 64'(end_cnt), 64'd1);
            chk($sformatf("v%0d_windows", i), 64'(windows), 64'(vecs[i].bursts));
            chk($sformatf("v%0d_br_rises", i), 64'(br_rises), 64'(vecs[i].rises));
            chk($sformatf("v%0d_leftover", i), 64'(exp_q.size()), 64'd0);
        end
        sel = 1'b0;

        // Grant withdrawn for 3 cycles in the middle of a write window.
        clear_mon();
        queue_bursts(16'h0040, 1);
        issue_cmd(0, 16'h0040, 16'd4);
        for (int i = 0; i < 50 && w_hi < 2; i++) step();
        chk("bgdrop_reached_write", 64'(w_hi), 64'd2);
        bg_block = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bgdrop_br_held", 64'(m_br), 64'd1);
            chk("bgdrop_writem_off", 64'(m_w === 1'b1), 64'd0);
        end
        bg_block = 1'b0;
        wait_end(100, t);
        chk("bgdrop_write_cycles", 64'(w_hi), 64'(LAT));
        chk("bgdrop_windows", 64'(windows), 64'd1);
        chk("bgdrop_end", 64'(end_cnt), 64'd1);

        // Device not ready for 5 cycles while in LOAD.
        step();
        clear_mon();
        dev_en = 1'b0;
        queue_bursts(16'h0080, 1);
        issue_cmd(0, 16'h0080, 16'd4);
        for (int i = 0; i < 6; i++) step();
        chk("stall_br_held", 64'(m_br), 64'd1);
        chk("stall_ready", 64'(m_rdy), 64'd1);
        chk("stall_no_write", 64'(w_hi), 64'd0);
        dev_en = 1'b1;
        refresh_dev();
        wait_end(100, t);
        chk("stall_windows", 64'(windows), 64'd1);
        chk("stall_end", 64'(end_cnt), 64'd1);

        // Reset in the first write cycle of the second burst.
        step();
        clear_mon();
        queue_bursts(16'h0200, 2);
        issue_cmd(0, 16'h0200, 16'd8);
        for (int i = 0; i < 50 && w_hi < LAT + 1; i++) step();
        chk("rst_reached_burst2", 64'(w_hi), 64'(LAT + 1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_br", 64'(m_br), 64'd0);
        chk("rst_busy", 64'(m_busy), 64'd0);
        chk("rst_bus_off", 64'(bus_off()), 64'd1);
        exp_q.delete();
        dev_q.delete();
        refresh_dev();
        wcount = 0;
        for (int i = 0; i < 6; i++) step();
        chk("rst_no_end", 64'(end_cnt), 64'd0);
        chk("rst_no_write", 64'(wcount), 64'd0);

        // Fresh command after reset; a second cmd while busy must be ignored.
        clear_mon();
        queue_bursts(16'h0300, 1);
        issue_cmd(0, 16'h0300, 16'd4);
        for (int i = 0; i < 50 && w_hi < 1; i++) step();
        issue_cmd(0, 16'h0500, 16'd8);
        wait_end(100, t);
        step();
        for (int i = 0; i < 10; i++) step();
        chk("busycmd_windows", 64'(windows), 64'd1);
        chk("busycmd_end", 64'(end_cnt), 64'd1);
        chk("busycmd_br_low", 64'(m_br), 64'd0);
        chk("busycmd_busy_low", 64'(m_busy), 64'd0);
        chk("busycmd_leftover", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
